uart_cmd_responder: RTL and testbench

Device-side command responder for the UART link: consumes received bytes from the UART receiver, decodes host read/write command frames, runs one transaction on the internal register bus, and returns a one-byte reply through the UART transmitter. It sits between the UART wrapper's RX/TX byte ports and the peripheral register bus, giving an external host register access over the serial line.

---
 rtl/uart_cmd_responder.sv | 175 +++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Device-side command responder: decodes host read/write frames from UART RX bytes,
// runs one register-bus transaction and answers with a single reply byte over UART TX.
module uart_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_SEND,
    ST_WAIT_TX
  } state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       bus_addr_q, bus_addr_d;
  logic [7:0]       bus_wdata_q, bus_wdata_d;
  logic             err_q, err_d;

  logic timeout;
  logic counting;

  assign timeout  = (cnt_q == CNT_LAST);
  assign counting = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) ||
                    (state_q == ST_BUS_WR)   || (state_q == ST_BUS_RD);

  // State register: everything sequential lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order or of other always_ff blocks.
      state_q     <= state_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. Within GET_* a byte beats the timeout; within BUS_* the ack does.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) state_d = ST_GET_ADDR;
          else                                                 state_d = ST_SEND;
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid)     state_d = wr_q ? ST_GET_DATA : ST_BUS_RD;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (rx_valid)     state_d = ST_BUS_WR;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_BUS_WR, ST_BUS_RD: begin
        if (bus_ack || timeout) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    wr_d        = wr_q;
    tx_data_d   = tx_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          wr_d = (rx_data == OP_WRITE);
          if ((rx_data != OP_WRITE) && (rx_data != OP_READ)) begin
            tx_data_d = REPLY_NAK;
            err_d     = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid)     bus_addr_d = rx_data;
        else if (timeout) err_d = 1'b1;
      end
      ST_GET_DATA: begin
        if (rx_valid)     bus_wdata_d = rx_data;
        else if (timeout) err_d = 1'b1;
      end
      ST_BUS_WR: begin
        if (bus_ack) begin
          tx_data_d = REPLY_ACK;
        end else if (timeout) begin
          tx_data_d = REPLY_NAK;
          err_d     = 1'b1;
        end
      end
      ST_BUS_RD: begin
        if (bus_ack) begin
          tx_data_d = bus_rdata;
        end else if (timeout) begin
          tx_data_d = REPLY_NAK;
          err_d     = 1'b1;
        end
      end
      default: ;
    endcase

    // Every accepted byte changes state, so a state change covers both clear conditions.
    if (state_d != state_q) cnt_d = '0;
    else if (counting)      cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = '0;
  end

  // Output logic. Requests follow the state so reset or exit drops them next cycle.
  always_comb begin
    tx_en     = (state_q == ST_SEND) && !tx_busy;
    bus_we    = (state_q == ST_BUS_WR);
    bus_re    = (state_q == ST_BUS_RD);
    tx_data   = tx_data_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
    err       = err_q;
  end

  a_one_request: assert property (@(posedge clk) disable iff (rst) !(bus_we && bus_re));

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: write, read, bad opcode, frame and bus
// timeouts, reset mid-transaction and a byte dropped while a reply is in flight.
module tb_uart_cmd_responder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  int n_txen = 0, n_err = 0, n_we = 0, n_re = 0, n_both = 0;
  int b_txen, b_err, b_we, b_re;

  always #5 clk = ~clk;

  uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_en)            n_txen++;
      if (err)              n_err++;
      if (bus_we)           n_we++;
      if (bus_re)           n_re++;
      if (bus_we && bus_re) n_both++;
    end
  end

  // Transmitter model: busy from the cycle after tx_en, tx_done three cycles later.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && !rst) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    next_cycle();
    rx_valid = 1'b0;
  endtask

  task automatic wait_reply();
    repeat (8) next_cycle();
  endtask

  task automatic snap();
    b_txen = n_txen;
    b_err  = n_err;
    b_we   = n_we;
    b_re   = n_re;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) next_cycle();
    settle();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_bus_addr", bus_addr, 8'h00);
    check("rst_bus_wdata", bus_wdata, 8'h00);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_re", bus_re, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    next_cycle();

    // Write 0x57 0x10 0xA5, ack in the third bus_we cycle.
    snap();
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    settle();
    check("wr_we_high", bus_we, 1'b1);
    check("wr_re_low", bus_re, 1'b0);
    check("wr_addr", bus_addr, 8'h10);
    check("wr_wdata", bus_wdata, 8'hA5);
    next_cycle(); next_cycle();
    bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    settle();
    check("wr_we_drop", bus_we, 1'b0);
    check("wr_tx_en", tx_en, 1'b1);
    check("wr_reply", tx_data, 8'h06);
    check("wr_we_cycles", n_we - b_we, 3);
    wait_reply();
    check("wr_one_reply", n_txen - b_txen, 1);
    check("wr_no_err", n_err - b_err, 0);

    // Read 0x52 0x22, ack immediately with 0x3C.
    snap();
    send_byte(8'h52); send_byte(8'h22);
    settle();
    check("rd_re_high", bus_re, 1'b1);
    check("rd_we_low", bus_we, 1'b0);
    check("rd_addr", bus_addr, 8'h22);
    bus_rdata = 8'h3C; bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0; bus_rdata = 8'hFF;
    settle();
    check("rd_tx_en", tx_en, 1'b1);
    check("rd_reply", tx_data, 8'h3C);
    check("rd_re_drop", bus_re, 1'b0);
    wait_reply();
    check("rd_no_we", n_we - b_we, 0);
    check("rd_re_cycles", n_re - b_re, 1);
    check("rd_no_err", n_err - b_err, 0);

    // Bad opcode 0x41, then a normal read 0x52 0x01.
    snap();
    send_byte(8'h41);
    settle();
    check("bad_err", err, 1'b1);
    check("bad_nak", tx_data, 8'h15);
    next_cycle(); settle();
    check("bad_err_width", err, 1'b0);
    wait_reply();
    check("bad_one_reply", n_txen - b_txen, 1);
    check("bad_no_bus", (n_we - b_we) + (n_re - b_re), 0);
    check("bad_err_count", n_err - b_err, 1);
    send_byte(8'h52); send_byte(8'h01);
    settle();
    check("bad_next_addr", bus_addr, 8'h01);
    bus_rdata = 8'h5A; bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    settle();
    check("bad_next_reply", tx_data, 8'h5A);
    wait_reply();

    // Frame timeout: silence after 0x57 0x10; threshold is 15 cycles into GET_DATA.
    snap();
    send_byte(8'h57); send_byte(8'h10);
    repeat (15) next_cycle();
    settle();
    check("fto_no_err_yet", err, 1'b0);
    next_cycle(); settle();
    check("fto_err", err, 1'b1);
    next_cycle(); settle();
    check("fto_err_width", err, 1'b0);
    wait_reply();
    check("fto_no_reply", n_txen - b_txen, 0);
    check("fto_no_bus", n_we - b_we, 0);

    // Byte landing exactly on the frame-timeout threshold is accepted.
    snap();
    send_byte(8'h57); send_byte(8'h10);
    repeat (15) next_cycle();
    send_byte(8'h77);
    settle();
    check("fto_edge_no_err", err, 1'b0);
    check("fto_edge_we", bus_we, 1'b1);
    check("fto_edge_wdata", bus_wdata, 8'h77);
    bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    settle();
    check("fto_edge_reply", tx_data, 8'h06);
    wait_reply();
    check("fto_edge_err_count", n_err - b_err, 0);

    // Bus timeout: read with no ack.
    snap();
    send_byte(8'h52); send_byte(8'h33);
    repeat (16) next_cycle();
    settle();
    check("bto_re_drop", bus_re, 1'b0);
    check("bto_err", err, 1'b1);
    check("bto_nak", tx_data, 8'h15);
    check("bto_tx_en", tx_en, 1'b1);
    check("bto_re_cycles", n_re - b_re, 16);
    wait_reply();
    check("bto_one_reply", n_txen - b_txen, 1);

    // Reset while bus_we is high; a stray ack afterwards is ignored.
    snap();
    send_byte(8'h57); send_byte(8'h44); send_byte(8'h55);
    settle();
    check("rstw_we_high", bus_we, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    check("rstw_we_low", bus_we, 1'b0);
    check("rstw_addr", bus_addr, 8'h00);
    check("rstw_wdata", bus_wdata, 8'h00);
    check("rstw_tx_data", tx_data, 8'h00);
    bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    wait_reply();
    check("rstw_no_reply", n_txen - b_txen, 0);
    check("rstw_no_err", n_err - b_err, 0);

    // A byte arriving in WAIT_TX is dropped.
    snap();
    send_byte(8'h52); send_byte(8'h05);
    bus_rdata = 8'h11; bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    settle();
    check("wtx_tx_en", tx_en, 1'b1);
    next_cycle();
    send_byte(8'h41);
    wait_reply();
    check("wtx_one_reply", n_txen - b_txen, 1);
    check("wtx_no_err", n_err - b_err, 0);
    check("wtx_data_held", tx_data, 8'h11);

    check("never_both_req", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
